// File: rtl/fft_bitrev_reorder.sv
// Reorders FFT output frames from bit-reversed to natural bin order using a
// ping-pong pair of N-word banks; one bank fills while the other drains.
module fft_bitrev_reorder #(
  parameter int LOG2N = 10,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          n_reset,
  input  logic          i_strb,
  input  logic [DW-1:0] i_data,
  output logic          o_strb,
  output logic [DW-1:0] o_data,
  output logic          o_sof,
  output logic          o_eof
);

  localparam int N = 1 << LOG2N;
  localparam logic [LOG2N-1:0] LAST = '1;

  typedef enum logic {IDLE, READ} state_t;

  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] a);
    logic [LOG2N-1:0] r;
    for (int i = 0; i < LOG2N; i++) r[i] = a[LOG2N-1-i];
    return r;
  endfunction

  // Both banks live in one array; the top address bit is the bank select.
  logic [DW-1:0]    mem [0:2*N-1];

  logic [LOG2N-1:0] wcnt;
  logic             wbank;
  logic             frame_done;

  state_t           state, state_nxt;
  logic [LOG2N-1:0] rcnt, rcnt_nxt;
  logic             rbank, rbank_nxt;
  logic             rd_en_p0;

  logic [DW-1:0]    rd_data_p1;
  logic             vld_p1;
  logic             sof_p1;
  logic             eof_p1;

  assign frame_done = i_strb && (wcnt == LAST);

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      wcnt  <= '0;
      wbank <= 1'b0;
    end else if (i_strb) begin
      wcnt <= wcnt + LOG2N'(1);
      if (frame_done) wbank <= ~wbank;
    end
  end

  always_ff @(posedge clk) begin
    if (i_strb) mem[{wbank, bitrev(wcnt)}] <= i_data;
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state <= IDLE;
      rcnt  <= '0;
      rbank <= 1'b0;
    end else begin
      state <= state_nxt;
      rcnt  <= rcnt_nxt;
      rbank <= rbank_nxt;
    end
  end

  // A completed frame always (re)starts the burst on the bank just filled;
  // this also covers a completion landing on the last read address.
  always_comb begin
    state_nxt = state;
    rcnt_nxt  = rcnt;
    rbank_nxt = rbank;
    if (frame_done) begin
      state_nxt = READ;
      rcnt_nxt  = '0;
      rbank_nxt = wbank;
    end else begin
      case (state)
        IDLE: begin
          rcnt_nxt = '0;
        end
        READ: begin
          if (rcnt == LAST) begin
            state_nxt = IDLE;
            rcnt_nxt  = '0;
          end else begin
            rcnt_nxt = rcnt + LOG2N'(1);
          end
        end
        default: begin
          state_nxt = IDLE;
          rcnt_nxt  = '0;
        end
      endcase
    end
  end

  assign rd_en_p0 = (state == READ);

  // Stage p0 -> p1: registered memory read
  always_ff @(posedge clk) begin
    if (rd_en_p0) rd_data_p1 <= mem[{rbank, rcnt}];
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      vld_p1 <= 1'b0;
      sof_p1 <= 1'b0;
      eof_p1 <= 1'b0;
    end else begin
      vld_p1 <= rd_en_p0;
      sof_p1 <= rd_en_p0 && (rcnt == '0);
      eof_p1 <= rd_en_p0 && (rcnt == LAST);
    end
  end

  // Stage p1 -> p2: output registers; data holds between bursts
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      o_strb <= 1'b0;
      o_sof  <= 1'b0;
      o_eof  <= 1'b0;
      o_data <= '0;
    end else begin
      o_strb <= vld_p1;
      o_sof  <= sof_p1;
      o_eof  <= eof_p1;
      if (vld_p1) o_data <= rd_data_p1;
    end
  end

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Directed bench for fft_bitrev_reorder: N=1024 instance plus an N=8 instance.
module tb_fft_bitrev_reorder;

  logic        clk = 1'b0;
  logic        n_reset;
  logic        i_strb, i_strb8;
  logic [31:0] i_data, i_data8;
  logic        o_strb, o_sof, o_eof;
  logic [31:0] o_data;
  logic        o_strb8, o_sof8, o_eof8;
  logic [31:0] o_data8;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int bad_flag = 0;
  int last_edge = 0;
  int first_last = 0;

  logic [31:0] q_data[$];
  bit          q_sof[$];
  bit          q_eof[$];
  int          q_cyc[$];
  logic [31:0] q8_data[$];
  bit          q8_sof[$];
  bit          q8_eof[$];

  fft_bitrev_reorder #(.LOG2N(10), .DW(32)) dut (
    .clk(clk), .n_reset(n_reset), .i_strb(i_strb), .i_data(i_data),
    .o_strb(o_strb), .o_data(o_data), .o_sof(o_sof), .o_eof(o_eof)
  );

  fft_bitrev_reorder #(.LOG2N(3), .DW(32)) dut8 (
    .clk(clk), .n_reset(n_reset), .i_strb(i_strb8), .i_data(i_data8),
    .o_strb(o_strb8), .o_data(o_data8), .o_sof(o_sof8), .o_eof(o_eof8)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (o_strb) begin
      q_data.push_back(o_data);
      q_sof.push_back(o_sof);
      q_eof.push_back(o_eof);
      q_cyc.push_back(cyc);
    end
    if (!o_strb && (o_sof || o_eof)) bad_flag++;
    if (o_strb8) begin
      q8_data.push_back(o_data8);
      q8_sof.push_back(o_sof8);
      q8_eof.push_back(o_eof8);
    end
    if (!o_strb8 && (o_sof8 || o_eof8)) bad_flag++;
  end

  function automatic logic [9:0] bitrev10(input logic [9:0] a);
    logic [9:0] r;
    for (int i = 0; i < 10; i++) r[i] = a[9-i];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] d);
    i_data = d;
    i_strb = 1'b1;
    @(posedge clk);
    #1;
    last_edge = cyc;
    i_strb = 1'b0;
  endtask

  task automatic clear_q();
    q_data.delete();
    q_sof.delete();
    q_eof.delete();
    q_cyc.delete();
  endtask

  task automatic check_frame(input string tag, input int qoff, input int n,
                             input logic [31:0] base, input int first_cyc);
    for (int k = 0; k < n; k++) begin
      chk({tag, "_data"}, q_data[qoff+k], base + 32'(k));
      chk({tag, "_sof"}, q_sof[qoff+k], (k == 0) ? 64'd1 : 64'd0);
      chk({tag, "_eof"}, q_eof[qoff+k], (k == n-1) ? 64'd1 : 64'd0);
      chk({tag, "_cyc"}, q_cyc[qoff+k], 64'(first_cyc + k));
    end
  endtask

  initial begin
    n_reset = 1'b0;
    i_strb  = 1'b0;
    i_data  = '0;
    i_strb8 = 1'b0;
    i_data8 = '0;
    #3;
    chk("rst_strb", o_strb, 0);
    chk("rst_data", o_data, 0);
    chk("rst_sof", o_sof, 0);
    chk("rst_eof", o_eof, 0);
    idle(3);
    n_reset = 1'b1;
    idle(2);

    // continuous frame
    clear_q();
    for (int k = 0; k < 1024; k++) send({22'h0, bitrev10(10'(k))});
    idle(1030);
    chk("cont_count", q_data.size(), 1024);
    check_frame("cont", 0, 1024, 32'h0, last_edge + 2);
    chk("cont_hold", o_data, 32'd1023);
    chk("cont_idle_strb", o_strb, 0);

    // gapped frame, one strobe every third cycle
    clear_q();
    for (int k = 0; k < 1024; k++) begin
      send({22'h0, bitrev10(10'(k))});
      if (k != 1023) idle(2);
    end
    idle(1030);
    chk("gap_count", q_data.size(), 1024);
    check_frame("gap", 0, 1024, 32'h0, last_edge + 2);

    // back-to-back frames
    clear_q();
    for (int k = 0; k < 1024; k++) send({22'h0, bitrev10(10'(k))});
    first_last = last_edge;
    for (int k = 0; k < 1024; k++) send(32'h1000 + {22'h0, bitrev10(10'(k))});
    idle(1030);
    chk("b2b_count", q_data.size(), 2048);
    check_frame("b2b1", 0, 1024, 32'h0, first_last + 2);
    check_frame("b2b2", 1024, 1024, 32'h1000, first_last + 2 + 1024);

    // reset in the middle of an input frame
    clear_q();
    for (int k = 0; k < 500; k++) send(32'hDEAD_0000 + 32'(k));
    n_reset = 1'b0;
    idle(2);
    n_reset = 1'b1;
    idle(2);
    chk("rstin_none", q_data.size(), 0);
    for (int k = 0; k < 1024; k++) send(32'h2000 + {22'h0, bitrev10(10'(k))});
    idle(1030);
    chk("rstin_count", q_data.size(), 1024);
    check_frame("rstin", 0, 1024, 32'h2000, last_edge + 2);

    // reset while output word 100 is being presented
    clear_q();
    for (int k = 0; k < 1024; k++) send(32'h3000 + {22'h0, bitrev10(10'(k))});
    idle(102);
    chk("rstout_w100", o_data, 32'h3064);
    n_reset = 1'b0;
    #1;
    chk("rstout_strb", o_strb, 0);
    chk("rstout_data", o_data, 0);
    idle(2);
    n_reset = 1'b1;
    idle(1100);
    chk("rstout_count", q_data.size(), 100);
    chk("rstout_strb_idle", o_strb, 0);

    // N=8 instance
    begin
      logic [31:0] seq8 [8] = '{32'd0, 32'd4, 32'd2, 32'd6, 32'd1, 32'd5, 32'd3, 32'd7};
      for (int k = 0; k < 8; k++) begin
        i_data8 = seq8[k];
        i_strb8 = 1'b1;
        @(posedge clk);
        #1;
      end
      i_strb8 = 1'b0;
    end
    idle(12);
    chk("n8_count", q8_data.size(), 8);
    for (int k = 0; k < 8; k++) begin
      chk("n8_data", q8_data[k], 64'(k));
      chk("n8_sof", q8_sof[k], (k == 0) ? 64'd1 : 64'd0);
      chk("n8_eof", q8_eof[k], (k == 7) ? 64'd1 : 64'd0);
    end

    chk("flags_without_strb", bad_flag, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fft_bitrev_reorder.md
FFT_BITREV_REORDER -- requirements
Module: fft_bitrev_reorder

Interface
REQ-001 Parameter LOG2N, default 10, log2 of FFT frame length N (N = 2^LOG2N = 1024); SHALL match the upstream FFT pipeline length.
REQ-002 Parameter DW, default 32, data word width ({re[15:0], im[15:0]} packed, passed through unmodified).
REQ-003 clk  input  1  single clock; all state SHALL be updated on rising edge.
REQ-004 n_reset  input  1  asynchronous, active-low reset.
REQ-005 i_strb  input  1  input word valid; one word captured per clk edge with i_strb=1; gaps of any length allowed.
REQ-006 i_data  input  DW  FFT output word, arriving in bit-reversed bin order.
REQ-007 o_strb  output  1  output word valid.
REQ-008 o_data  output  DW  FFT bin, natural order 0..N-1.
REQ-009 o_sof  output  1  high with bin 0 of each output frame (qualified by o_strb).
REQ-010 o_eof  output  1  high with bin N-1 of each output frame (qualified by o_strb).

Function
REQ-011 Block SHALL contain two N x DW memory banks (ping-pong); one write bank, one read bank at any time.
REQ-012 Write counter wcnt (LOG2N bits) SHALL increment on each i_strb; the word SHALL be written to the write bank at address bitrev(wcnt).
REQ-013 When the word with wcnt = N-1 is written, wcnt SHALL wrap to 0, bank roles SHALL swap on the same edge, and a read frame SHALL be started.
REQ-014 Read FSM states: IDLE, READ. IDLE->READ on frame-complete; READ->IDLE after issuing address N-1 unless a frame-complete occurs on that same edge, in which case it SHALL remain in READ with rcnt = 0 on the newly completed bank.
REQ-015 In READ, read address rcnt SHALL increment by one every cycle with no stall; the read bank is latched at READ entry.
REQ-016 Memory read SHALL be registered; o_data, o_strb, o_sof, o_eof SHALL be registered outputs.
REQ-017 Latency: with the last input word of a frame captured at edge E, bin 0 SHALL be presented after edge E+2 and bin k after edge E+2+k; o_strb high for exactly N consecutive cycles per frame.
REQ-018 Because each frame needs >= N input cycles, a read burst SHALL always finish before the next swap; back-to-back input frames SHALL yield back-to-back output bursts with zero idle cycles.
REQ-019 o_data SHALL hold its last value when o_strb=0; o_sof/o_eof SHALL be 0 when o_strb=0.
REQ-020 No data arithmetic; o_data SHALL equal the stored i_data bit-for-bit.

Reset
REQ-021 On n_reset=0: wcnt=0, rcnt=0, bank select=0, FSM=IDLE, o_strb=0, o_data=0, o_sof=0, o_eof=0, asynchronously.
REQ-022 Reset mid-input-frame SHALL discard the partial frame; reset mid-output-burst SHALL terminate the burst immediately with no further words from that frame.
REQ-023 Memory contents need not be reset; no stale content SHALL ever be output because reads occur only after a complete frame write.

Verification
REQ-024 Continuous: 1024 strobes, i_data = {22'h0, bitrev10(k)} for k=0..1023 -> o_data = 0..1023 on 1024 consecutive cycles, first at 2 edges after last input, o_sof with 0, o_eof with 1023.
REQ-025 Gapped: same frame with i_strb every 3rd cycle -> identical output burst, 1024 consecutive strobes, 2-edge latency from last input.
REQ-026 Back-to-back: 2048 continuous strobes (frame 2 data = 0x1000 + bitrev10(k)) -> 2048 consecutive output strobes, no gap, 0..1023 then 0x1000..0x13FF, two o_sof pulses 1024 cycles apart.
REQ-027 Reset after 500 input words, then one full frame -> exactly 1024 outputs, all from the new frame, natural order.
REQ-028 Reset asserted during output word 100 -> o_strb=0 immediately, no outputs until a subsequent complete frame.
REQ-029 LOG2N=3: inputs 0,4,2,6,1,5,3,7 -> outputs 0,1,2,3,4,5,6,7 with o_sof on 0, o_eof on 7.
